// File: rtl/mini_src_pkg.sv
// Shared definitions for the Mini SRC control sequencer.
//   - opcode constants recognised by the sequencer (ld, ldi, st)
//   - BusDataSelect source codes and the ALU add operation code
//   - the sequencer state enum and the packed control-word struct
//   - helpers: per-state control decode, retire-state test, opcode check
package mini_src_pkg;

  localparam logic [4:0] OP_LD  = 5'b00000;
  localparam logic [4:0] OP_LDI = 5'b00001;
  localparam logic [4:0] OP_ST  = 5'b00010;

  localparam logic [4:0] BUS_GPR = 5'b00000;
  localparam logic [4:0] BUS_ZLO = 5'b10011;
  localparam logic [4:0] BUS_PC  = 5'b10100;
  localparam logic [4:0] BUS_MDR = 5'b10101;

  localparam logic [3:0] ALU_NOP = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0011;

  // Width of the RAM wait counter; covers MEM_WAIT up to 15.
  localparam int unsigned MEM_WAIT_W = 4;

  typedef enum logic [4:0] {
    S_IDLE    = 5'd0,
    S_F0      = 5'd1,
    S_F1      = 5'd2,
    S_F2      = 5'd3,
    S_F3      = 5'd4,
    S_DEC     = 5'd5,
    S_E3      = 5'd6,
    S_E4      = 5'd7,
    S_LDI_E5  = 5'd8,
    S_LD_E5   = 5'd9,
    S_LD_E6   = 5'd10,
    S_LD_E7   = 5'd11,
    S_LD_E8   = 5'd12,
    S_ST_E5   = 5'd13,
    S_ST_E6   = 5'd14,
    S_ST_E7   = 5'd15,
    S_ILLEGAL = 5'd16
  } seq_state_t;

  typedef struct packed {
    logic       inc_pc;
    logic       e_mar;
    logic       e_mdr;
    logic       mdr_read;
    logic       e_ir;
    logic       e_y;
    logic       e_z;
    logic       gra;
    logic       grb;
    logic       ba_out;
    logic       e_rin;
    logic       e_rout;
    logic       imm_sel;
    logic       ram_read;
    logic       ram_write;
    logic       illegal;
    logic       busy;
    logic [3:0] alu_op;
    logic [4:0] bus_sel;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  // Control word that is presented while the sequencer sits in a given state.
  function automatic ctrl_t state_ctrl(input seq_state_t st);
    ctrl_t c;
    c         = CTRL_NONE;
    c.busy    = (st != S_IDLE);
    c.alu_op  = ALU_NOP;
    c.bus_sel = BUS_GPR;
    case (st)
      S_F0: begin
        c.bus_sel = BUS_PC;
        c.e_mar   = 1'b1;
        c.inc_pc  = 1'b1;
      end
      S_F1, S_LD_E6: c.ram_read = 1'b1;
      S_F2, S_LD_E7: begin
        c.mdr_read = 1'b1;
        c.e_mdr    = 1'b1;
      end
      S_F3: begin
        c.bus_sel = BUS_MDR;
        c.e_ir    = 1'b1;
      end
      S_E3: begin
        c.grb     = 1'b1;
        c.ba_out  = 1'b1;
        c.bus_sel = BUS_GPR;
        c.e_y     = 1'b1;
      end
      S_E4: begin
        c.imm_sel = 1'b1;
        c.alu_op  = ALU_ADD;
        c.e_z     = 1'b1;
      end
      S_LDI_E5: begin
        c.bus_sel = BUS_ZLO;
        c.gra     = 1'b1;
        c.e_rin   = 1'b1;
      end
      S_LD_E5, S_ST_E5: begin
        c.bus_sel = BUS_ZLO;
        c.e_mar   = 1'b1;
      end
      S_LD_E8: begin
        c.bus_sel = BUS_MDR;
        c.gra     = 1'b1;
        c.e_rin   = 1'b1;
      end
      S_ST_E6: begin
        c.gra     = 1'b1;
        c.e_rout  = 1'b1;
        c.bus_sel = BUS_GPR;
      end
      // Store data stays on the bus during the single write cycle.
      S_ST_E7: begin
        c.gra       = 1'b1;
        c.e_rout    = 1'b1;
        c.bus_sel   = BUS_GPR;
        c.ram_write = 1'b1;
      end
      S_ILLEGAL: c.illegal = 1'b1;
      default:   c.busy    = c.busy;
    endcase
    return c;
  endfunction

  // Final execute state of an instruction; the retire counter steps when entered.
  function automatic logic is_retire_state(input seq_state_t st);
    return (st == S_LDI_E5) || (st == S_LD_E8) || (st == S_ST_E7);
  endfunction

  function automatic logic op_supported(input logic [4:0] op);
    return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// RAM wait timer for the ldst sequencer.
// Loaded with WAIT-1 on the cycle before a RAM read phase starts, then counts
// down once per cycle of that phase; 'expired' marks the last read cycle.
// Ports:
//   clock   in  system clock
//   clear   in  synchronous active-high reset
//   load    in  reload the counter with WAIT-1
//   count   in  decrement while non-zero
//   expired out counter has reached zero
module mem_wait_timer
  import mini_src_pkg::*;
#(
  parameter int unsigned WAIT = 1
) (
  input  logic clock,
  input  logic clear,
  input  logic load,
  input  logic count,
  output logic expired
);

  logic [MEM_WAIT_W-1:0] count_r;

  // Count-down register; holds at zero once expired.
  always_ff @(posedge clock) begin
    if (clear) begin
      count_r <= {MEM_WAIT_W{1'b0}};
    end else if (load) begin
      count_r <= MEM_WAIT_W'(WAIT - 1);
    end else if (count && (count_r != {MEM_WAIT_W{1'b0}})) begin
      count_r <= count_r - {{(MEM_WAIT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == {MEM_WAIT_W{1'b0}});

endmodule

// File: rtl/ldst_sequencer.sv
// Mini SRC control sequencer: drives every datapath strobe for instruction
// fetch and for ld / ldi / st execution, and counts retired instructions.
// Outputs are registered Moore outputs: the control word for the next state
// is registered together with the state, so strobes line up with the state.
// Ports:
//   clock, clear          clock and synchronous active-high reset
//   run                   level; fetch/execute continuously while high
//   step                  (LDST_SEQ_SINGLE_STEP_EN only) one instruction per pulse
//   ir_op                 IR[31:27]
//   incPC .. imm_sel      datapath register strobes and select controls
//   ram_read, ram_write   RAM strobes
//   ALU_op, BusDataSelect ALU operation and bus source code
//   busy, illegal         status; illegal pulses on an unsupported opcode
//   retired               wrapping count of completed ld/ldi/st
// Configuration macro: LDST_SEQ_SINGLE_STEP_EN adds the step port; after each
// retire or illegal the sequencer idles until step is seen high.
module ldst_sequencer
  import mini_src_pkg::*;
#(
  parameter int unsigned MEM_WAIT  = 1,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned BUS_SEL_W = 5,
  parameter int unsigned ALU_OP_W  = 4
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 run,
`ifdef LDST_SEQ_SINGLE_STEP_EN
  input  logic                 step,
`endif
  input  logic [4:0]           ir_op,
  output logic                 incPC,
  output logic                 e_MAR,
  output logic                 e_MDR,
  output logic                 MDR_read,
  output logic                 e_IR,
  output logic                 e_Y,
  output logic                 e_Z,
  output logic                 Gra,
  output logic                 Grb,
  output logic                 BAout,
  output logic                 e_Rin,
  output logic                 e_Rout,
  output logic                 imm_sel,
  output logic                 ram_read,
  output logic                 ram_write,
  output logic [ALU_OP_W-1:0]  ALU_op,
  output logic [BUS_SEL_W-1:0] BusDataSelect,
  output logic                 busy,
  output logic                 illegal,
  output logic [CNT_W-1:0]     retired
);

  seq_state_t       state_r;
  seq_state_t       state_next_s;
  seq_state_t       after_retire_s;
  logic [4:0]       op_r;
  ctrl_t            ctrl_r;
  logic [CNT_W-1:0] retired_r;
  logic             start_s;
  logic             timer_load_s;
  logic             timer_count_s;
  logic             timer_expired_s;

  // Reload the wait timer on the cycle before each RAM read phase.
  assign timer_load_s  = (state_r == S_F0) || (state_r == S_LD_E5);
  assign timer_count_s = (state_r == S_F1) || (state_r == S_LD_E6);

  mem_wait_timer #(
    .WAIT (MEM_WAIT)
  ) u_mem_wait_timer (
    .clock   (clock),
    .clear   (clear),
    .load    (timer_load_s),
    .count   (timer_count_s),
    .expired (timer_expired_s)
  );

`ifdef LDST_SEQ_SINGLE_STEP_EN
  logic step_wait_r;

  // Set after each retire/illegal; released by a step pulse seen in S_IDLE.
  always_ff @(posedge clock) begin
    if (clear) begin
      step_wait_r <= 1'b0;
    end else if (is_retire_state(state_r) || (state_r == S_ILLEGAL)) begin
      step_wait_r <= 1'b1;
    end else if ((state_r == S_IDLE) && step) begin
      step_wait_r <= 1'b0;
    end else begin
      step_wait_r <= step_wait_r;
    end
  end

  // Start condition from idle: step while waiting, otherwise run.
  always_comb begin
    start_s        = 1'b0;
    after_retire_s = S_IDLE;
    if (step_wait_r) begin
      start_s = step;
    end else begin
      start_s = run;
    end
  end
`else
  // Start condition from idle and the state that follows a retire.
  always_comb begin
    start_s        = run;
    after_retire_s = S_IDLE;
    if (run) begin
      after_retire_s = S_F0;
    end else begin
      after_retire_s = S_IDLE;
    end
  end
`endif

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_s) begin
          state_next_s = S_F0;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_F0: state_next_s = S_F1;
      S_F1: begin
        if (timer_expired_s) begin
          state_next_s = S_F2;
        end else begin
          state_next_s = S_F1;
        end
      end
      S_F2: state_next_s = S_F3;
      S_F3: state_next_s = S_DEC;
      S_DEC: begin
        if (op_supported(ir_op)) begin
          state_next_s = S_E3;
        end else begin
          state_next_s = S_ILLEGAL;
        end
      end
      S_E3: state_next_s = S_E4;
      // Opcode was latched in DEC so the branch does not depend on ir_op later.
      S_E4: begin
        case (op_r)
          OP_LDI:  state_next_s = S_LDI_E5;
          OP_LD:   state_next_s = S_LD_E5;
          OP_ST:   state_next_s = S_ST_E5;
          default: state_next_s = S_ILLEGAL;
        endcase
      end
      S_LD_E5: state_next_s = S_LD_E6;
      S_LD_E6: begin
        if (timer_expired_s) begin
          state_next_s = S_LD_E7;
        end else begin
          state_next_s = S_LD_E6;
        end
      end
      S_LD_E7: state_next_s = S_LD_E8;
      S_ST_E5: state_next_s = S_ST_E6;
      S_ST_E6: state_next_s = S_ST_E7;
      S_LDI_E5, S_LD_E8, S_ST_E7: state_next_s = after_retire_s;
      S_ILLEGAL: state_next_s = S_IDLE;
      default:   state_next_s = S_IDLE;
    endcase
  end

  // State, latched opcode, registered control word and retire counter.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_r   <= S_IDLE;
      op_r      <= 5'b00000;
      ctrl_r    <= CTRL_NONE;
      retired_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      ctrl_r  <= state_ctrl(state_next_s);
      if (state_r == S_DEC) begin
        op_r <= ir_op;
      end else begin
        op_r <= op_r;
      end
      // Counts up as the final execute state is entered; wraps naturally.
      if (is_retire_state(state_next_s)) begin
        retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        retired_r <= retired_r;
      end
    end
  end

  assign incPC         = ctrl_r.inc_pc;
  assign e_MAR         = ctrl_r.e_mar;
  assign e_MDR         = ctrl_r.e_mdr;
  assign MDR_read      = ctrl_r.mdr_read;
  assign e_IR          = ctrl_r.e_ir;
  assign e_Y           = ctrl_r.e_y;
  assign e_Z           = ctrl_r.e_z;
  assign Gra           = ctrl_r.gra;
  assign Grb           = ctrl_r.grb;
  assign BAout         = ctrl_r.ba_out;
  assign e_Rin         = ctrl_r.e_rin;
  assign e_Rout        = ctrl_r.e_rout;
  assign imm_sel       = ctrl_r.imm_sel;
  assign ram_read      = ctrl_r.ram_read;
  assign ram_write     = ctrl_r.ram_write;
  assign ALU_op        = ALU_OP_W'(ctrl_r.alu_op);
  assign BusDataSelect = BUS_SEL_W'(ctrl_r.bus_sel);
  assign busy          = ctrl_r.busy;
  assign illegal       = ctrl_r.illegal;
  assign retired       = retired_r;

endmodule

// File: tb/tb_ldst_sequencer.sv
// Bench for ldst_sequencer. Two instances: dut0 (MEM_WAIT=1, CNT_W=3 so the
// retire counter wraps quickly) and dut1 (MEM_WAIT=3, CNT_W=16). Expected
// per-cycle control words are pushed to a scoreboard queue when an
// instruction is launched and compared cycle by cycle on the falling edge.
module tb_ldst_sequencer;

  localparam logic [16:0] INC  = 17'h00001;
  localparam logic [16:0] MAR  = 17'h00002;
  localparam logic [16:0] MDR  = 17'h00004;
  localparam logic [16:0] MRD  = 17'h00008;
  localparam logic [16:0] IR   = 17'h00010;
  localparam logic [16:0] EY   = 17'h00020;
  localparam logic [16:0] EZ   = 17'h00040;
  localparam logic [16:0] IMM  = 17'h00080;
  localparam logic [16:0] GRA  = 17'h00100;
  localparam logic [16:0] GRB  = 17'h00200;
  localparam logic [16:0] BAO  = 17'h00400;
  localparam logic [16:0] RIN  = 17'h00800;
  localparam logic [16:0] ROUT = 17'h01000;
  localparam logic [16:0] RRD  = 17'h02000;
  localparam logic [16:0] RWR  = 17'h04000;
  localparam logic [16:0] ILL  = 17'h08000;
  localparam logic [16:0] BSY  = 17'h10000;

  localparam logic [4:0] B_GPR = 5'b00000;
  localparam logic [4:0] B_ZLO = 5'b10011;
  localparam logic [4:0] B_PC  = 5'b10100;
  localparam logic [4:0] B_MDR = 5'b10101;
  localparam logic [3:0] A_ADD = 4'b0011;
  localparam logic [3:0] A_NOP = 4'b0000;

  logic       clock;
  logic       clear;
  logic       run;
  logic [4:0] ir_op;
`ifdef LDST_SEQ_SINGLE_STEP_EN
  logic       step;
  int         step_drop_at;
`endif

  logic [1:0] inc_pc, e_mar, e_mdr, mdr_read, e_ir, e_y, e_z, gra, grb, ba_out;
  logic [1:0] e_rin, e_rout, imm_sel, ram_read, ram_write, busy, illegal;
  logic [3:0] alu_op [2];
  logic [4:0] bus_sel [2];
  logic [2:0]  ret0;
  logic [15:0] ret1;

  int          n_cmp;
  int          n_err;
  int          sel;
  string       tname;
  logic [15:0] exp_ret;
  logic [41:0] exp_q [$];

  ldst_sequencer #(.MEM_WAIT(1), .CNT_W(3), .BUS_SEL_W(5), .ALU_OP_W(4)) dut0 (
    .clock(clock), .clear(clear), .run(run),
`ifdef LDST_SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .ir_op(ir_op), .incPC(inc_pc[0]), .e_MAR(e_mar[0]), .e_MDR(e_mdr[0]),
    .MDR_read(mdr_read[0]), .e_IR(e_ir[0]), .e_Y(e_y[0]), .e_Z(e_z[0]),
    .Gra(gra[0]), .Grb(grb[0]), .BAout(ba_out[0]), .e_Rin(e_rin[0]),
    .e_Rout(e_rout[0]), .imm_sel(imm_sel[0]), .ram_read(ram_read[0]),
    .ram_write(ram_write[0]), .ALU_op(alu_op[0]), .BusDataSelect(bus_sel[0]),
    .busy(busy[0]), .illegal(illegal[0]), .retired(ret0)
  );

  ldst_sequencer #(.MEM_WAIT(3), .CNT_W(16), .BUS_SEL_W(5), .ALU_OP_W(4)) dut1 (
    .clock(clock), .clear(clear), .run(run),
`ifdef LDST_SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .ir_op(ir_op), .incPC(inc_pc[1]), .e_MAR(e_mar[1]), .e_MDR(e_mdr[1]),
    .MDR_read(mdr_read[1]), .e_IR(e_ir[1]), .e_Y(e_y[1]), .e_Z(e_z[1]),
    .Gra(gra[1]), .Grb(grb[1]), .BAout(ba_out[1]), .e_Rin(e_rin[1]),
    .e_Rout(e_rout[1]), .imm_sel(imm_sel[1]), .ram_read(ram_read[1]),
    .ram_write(ram_write[1]), .ALU_op(alu_op[1]), .BusDataSelect(bus_sel[1]),
    .busy(busy[1]), .illegal(illegal[1]), .retired(ret1)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [41:0] observe(input int g);
    logic [15:0] r;
    r = (g == 0) ? {13'd0, ret0} : ret1;
    return {r, busy[g], illegal[g], ram_write[g], ram_read[g], e_rout[g], e_rin[g],
            ba_out[g], grb[g], gra[g], imm_sel[g], e_z[g], e_y[g], e_ir[g],
            mdr_read[g], e_mdr[g], e_mar[g], inc_pc[g], alu_op[g], bus_sel[g]};
  endfunction

  task automatic push(input logic [16:0] s, input logic [3:0] a, input logic [4:0] b);
    exp_q.push_back({exp_ret, s, a, b});
  endtask

  task automatic bump_retired();
    logic [15:0] mask;
    mask    = (sel == 0) ? 16'h0007 : 16'hFFFF;
    exp_ret = (exp_ret + 16'd1) & mask;
  endtask

  // Reference sequence of one instruction on the selected instance.
  task automatic push_instr(input logic [4:0] op);
    int mw;
    mw = (sel == 0) ? 1 : 3;
    push(BSY | INC | MAR, A_NOP, B_PC);
    repeat (mw) push(BSY | RRD, A_NOP, B_GPR);
    push(BSY | MRD | MDR, A_NOP, B_GPR);
    push(BSY | IR, A_NOP, B_MDR);
    push(BSY, A_NOP, B_GPR);
    if (op == 5'b00001) begin
      push(BSY | GRB | BAO | EY, A_NOP, B_GPR);
      push(BSY | IMM | EZ, A_ADD, B_GPR);
      bump_retired();
      push(BSY | GRA | RIN, A_NOP, B_ZLO);
    end else if (op == 5'b00000) begin
      push(BSY | GRB | BAO | EY, A_NOP, B_GPR);
      push(BSY | IMM | EZ, A_ADD, B_GPR);
      push(BSY | MAR, A_NOP, B_ZLO);
      repeat (mw) push(BSY | RRD, A_NOP, B_GPR);
      push(BSY | MRD | MDR, A_NOP, B_GPR);
      bump_retired();
      push(BSY | GRA | RIN, A_NOP, B_MDR);
    end else if (op == 5'b00010) begin
      push(BSY | GRB | BAO | EY, A_NOP, B_GPR);
      push(BSY | IMM | EZ, A_ADD, B_GPR);
      push(BSY | MAR, A_NOP, B_ZLO);
      push(BSY | GRA | ROUT, A_NOP, B_GPR);
      bump_retired();
      push(BSY | GRA | ROUT | RWR, A_NOP, B_GPR);
    end else begin
      push(BSY | ILL, A_NOP, B_GPR);
    end
  endtask

  // Pops and compares one expected word per cycle; drops run after drop_run_at words.
  task automatic check_seq(input int drop_run_at);
    int          idx;
    logic [41:0] e;
    logic [41:0] a;
    idx = 0;
    while (exp_q.size() > 0) begin
      @(negedge clock);
      e = exp_q.pop_front();
      a = observe(sel);
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL %s cycle %0d: got ctrl=%h retired=%0d, expected ctrl=%h retired=%0d",
                 tname, idx, a[25:0], a[41:26], e[25:0], e[41:26]);
      end
      idx++;
      if (idx == drop_run_at) run = 1'b0;
`ifdef LDST_SEQ_SINGLE_STEP_EN
      if (idx == step_drop_at) step = 1'b0;
`endif
    end
  endtask

  task automatic do_clear();
    @(negedge clock);
    clear = 1'b1;
    run   = 1'b0;
`ifdef LDST_SEQ_SINGLE_STEP_EN
    step         = 1'b0;
    step_drop_at = -1;
`endif
    repeat (2) @(negedge clock);
    clear   = 1'b0;
    exp_ret = 16'd0;
    exp_q.delete();
  endtask

  // clear and run both high: everything stays zero.
  task automatic test_reset();
    logic [41:0] a;
    tname = "reset";
    clear = 1'b1;
    run   = 1'b1;
    ir_op = 5'b00001;
    repeat (3) begin
      @(negedge clock);
      for (int g = 0; g < 2; g++) begin
        a = observe(g);
        n_cmp++;
        if (a !== 42'd0) begin
          n_err++;
          $display("FAIL reset dut%0d: got %h, expected 0", g, a);
        end
      end
    end
    clear = 1'b0;
    run   = 1'b0;
  endtask

  // One instruction launched by a single-cycle run pulse, then idle.
  task automatic test_single(input string nm, input int s, input logic [4:0] op);
    tname = nm;
    sel   = s;
    do_clear();
    ir_op = op;
    push_instr(op);
    push(17'd0, A_NOP, B_GPR);
    run = 1'b1;
    check_seq(1);
  endtask

  // Illegal opcode after a legal one: retired holds, busy drops next cycle.
  task automatic test_illegal();
    tname = "illegal";
    sel   = 0;
    do_clear();
    ir_op = 5'b00001;
    push_instr(5'b00001);
    push(17'd0, A_NOP, B_GPR);
    run = 1'b1;
    check_seq(1);
    ir_op = 5'b11111;
    push_instr(5'b11111);
    push(17'd0, A_NOP, B_GPR);
    push(17'd0, A_NOP, B_GPR);
    run = 1'b1;
`ifdef LDST_SEQ_SINGLE_STEP_EN
    step         = 1'b1;
    step_drop_at = 1;
`endif
    check_seq(1);
  endtask

  // clear during the store write cycle: write is not extended.
  task automatic test_clear_during_write();
    logic [41:0] a;
    tname = "clear_in_write";
    sel   = 1;
    do_clear();
    ir_op = 5'b00010;
    push_instr(5'b00010);
    run = 1'b1;
    check_seq(1);
    clear = 1'b1;
    @(negedge clock);
    a = observe(1);
    n_cmp++;
    if (a !== 42'd0) begin
      n_err++;
      $display("FAIL clear_in_write: got %h, expected 0 (ram_write=%b)", a, ram_write[1]);
    end
    clear   = 1'b0;
    exp_ret = 16'd0;
  endtask

  // n instructions with run held; the last one ends in idle.
  task automatic test_back_to_back(input string nm, input int s, input int n, input logic [4:0] op);
    int last_start;
    tname      = nm;
    sel        = s;
    do_clear();
    ir_op      = op;
    last_start = 0;
    for (int i = 0; i < n; i++) begin
`ifdef LDST_SEQ_SINGLE_STEP_EN
      if (i > 0) push(17'd0, A_NOP, B_GPR);
`endif
      last_start = exp_q.size();
      push_instr(op);
    end
    push(17'd0, A_NOP, B_GPR);
    run = 1'b1;
`ifdef LDST_SEQ_SINGLE_STEP_EN
    step         = 1'b1;
    step_drop_at = last_start + 1;
`endif
    check_seq(last_start + 1);
  endtask

`ifdef LDST_SEQ_SINGLE_STEP_EN
  // run held: first instruction retires, then one per step pulse.
  task automatic test_single_step();
    tname = "single_step";
    sel   = 0;
    do_clear();
    ir_op = 5'b00001;
    push_instr(5'b00001);
    repeat (4) push(17'd0, A_NOP, B_GPR);
    run = 1'b1;
    check_seq(-1);
    push_instr(5'b00001);
    repeat (4) push(17'd0, A_NOP, B_GPR);
    step         = 1'b1;
    step_drop_at = 1;
    check_seq(-1);
    run = 1'b0;
  endtask
`endif

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    sel     = 0;
    exp_ret = 16'd0;
    clear   = 1'b1;
    run     = 1'b0;
    ir_op   = 5'b00000;
`ifdef LDST_SEQ_SINGLE_STEP_EN
    step         = 1'b0;
    step_drop_at = -1;
`endif
    test_reset();
    test_single("ldi_mw1", 0, 5'b00001);
    test_single("ldi_mw3", 1, 5'b00001);
    test_single("ld_mw3", 1, 5'b00000);
    test_single("ld_mw1", 0, 5'b00000);
    test_single("st_mw3", 1, 5'b00010);
    test_illegal();
    test_clear_during_write();
    test_back_to_back("back_to_back_st", 1, 2, 5'b00010);
    test_back_to_back("retired_wrap", 0, 9, 5'b00001);
`ifdef LDST_SEQ_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
